ksm_vec_fetch: RTL and testbench
================================

Name: ksm_vec_fetch

Overview:
- CPU-side initiator of the vector-fetch / unaddressed-read bus cycle. It is the counterpart of the KSM interrupt controller, which is the responder.
- Accepts interrupt-acknowledge and start-mode-read requests from the core sequencer. Drives strobe and unaddressed-read qualifier toward the controller, waits for acknowledge, and latches the returned 16-bit word.
- Enforces timeout and inter-cycle recovery. Sits between the KSM core microsequencer and the interrupt controller.

Parameters:
- TMO, 64, max cycles allowed from request acceptance to acknowledge before timeout (2..2**TMO_W-1)
- TMO_W, 8, timeout counter width

Ports:
- wb_clk_i  input  1  system clock
- wb_rst_n_i  input  1  reset, asynchronous, active-low
- wb_irq_i  input  1  vectored interrupt request from controller
- wb_dat_i  input  16  vector / mode-register word from controller
- wb_ack_i  input  1  acknowledge from controller
- wb_stb_o  output  1  fetch strobe to controller
- wb_una_o  output  1  unaddressed (mode register) read qualifier
- vec_req_i  input  1  one-cycle strobe: fetch interrupt vector
- una_req_i  input  1  one-cycle strobe: read start-mode register
- dat_o  output  16  latched result word
- done_o  output  1  one-cycle pulse: dat_o valid
- tmo_o  output  1  one-cycle pulse: cycle timed out
- kind_o  output  1  type of completed/failed cycle: 1 = unaddressed, 0 = vector
- busy_o  output  1  any request pending or cycle in progress

Behaviour:
- Reset (async, wb_rst_n_i=0):
  - All outputs 0; dat_o=0.
  - Pending flags pend_vec and pend_una cleared; timeout counter 0; FSM=IDLE.
- Request capture:
  - vec_req_i/una_req_i set pend_vec/pend_una, one deep.
  - A strobe arriving while the same flag is already set is merged.
  - A set in the same cycle as that flag's clear wins: the flag stays set and a new cycle follows.
- busy_o = pend_vec | pend_una | (FSM!=IDLE), registered.
- FSM states: IDLE, CYC, GAP.
  - IDLE, pend_una=1: go CYC with wb_stb_o=1, wb_una_o=1. Unaddressed read has priority and does not need wb_irq_i.
  - IDLE, else pend_vec=1 and wb_irq_i=1: go CYC with wb_stb_o=1, wb_una_o=0.
  - IDLE, pend_vec=1 and wb_irq_i=0: stay IDLE; the timeout counter increments.
  - CYC, wb_ack_i=1: latch dat_o<=wb_dat_i; done_o=1; kind_o=wb_una_o; clear that pending flag; drop wb_stb_o and wb_una_o; go GAP.
  - CYC, counter==TMO without ack: drop strobe; tmo_o=1; kind_o set; clear that flag; dat_o unchanged; go GAP.
  - GAP: exactly one cycle with wb_stb_o=0, so the controller re-arbitrates its priority; then go IDLE.
- Timing:
  - All outputs are registered.
  - Nominal latency: request strobe at edge 0 → wb_stb_o high after edge 1 → controller ack sampled at edge 2 → done_o high after edge 2, for one cycle.
  - Minimum spacing between strobes is 1 low cycle.
- Timeout counter:
  - Cleared on entering CYC and on entering IDLE from GAP.
  - Counts every cycle in CYC, and in IDLE while pend_vec & ~wb_irq_i.
  - Saturates at TMO.
  - Timeout in IDLE-wait: tmo_o=1, kind_o=0, pend_vec cleared, no strobe issued, FSM stays IDLE.
- wb_irq_i falling during a vector CYC is ignored, because the controller holds its request while strobe is high. The cycle ends only by ack or timeout.
- wb_ack_i outside CYC is ignored; no done_o is generated.
- done_o and tmo_o are never asserted in the same cycle.

Optional Feature:
- Macro KSM_VF_IRQSYNC_EN.
- Defined:
  - wb_irq_i passes through a 2-flop synchronizer (reset 0) before all use; vector-cycle start latency grows by 2 cycles.
  - Other inputs are unaffected (same clock domain).
- Undefined: wb_irq_i is used directly.

Test Plan:
- Reset, then una_req_i pulse with responder returning 16'o000340 → wb_una_o=wb_stb_o=1 for 1 cycle; done_o=1, kind_o=1, dat_o=16'o000340; 1 GAP cycle; busy_o=0 afterwards.
- wb_irq_i=1, vec_req_i pulse, responder vector 16'o000060 acked 1 cycle after strobe → done_o 2 cycles after request, kind_o=0, dat_o=16'o000060.
- vec_req_i and una_req_i in the same cycle with irq=1 → unaddressed cycle first, then GAP, then vector cycle; exactly two done_o pulses in order kind 1, then kind 0.
- TMO=8, vector cycle with responder never acking → wb_stb_o held 8 cycles, tmo_o pulse, kind_o=0, dat_o keeps the previous value, pend_vec cleared.
- vec_req_i with wb_irq_i=0 throughout, TMO=8 → no strobe ever, tmo_o after 8 cycles. Repeat with irq rising at cycle 3 → normal done_o.
- wb_rst_n_i pulsed low while in CYC → all outputs 0 immediately (asynchronous), no done_o/tmo_o after release, busy_o=0.

Source files
------------

// File: rtl/ksm_vec_fetch.sv
// KSM vector-fetch / unaddressed-read bus initiator with timeout and one-cycle recovery gap.
// Optional KSM_VF_IRQSYNC_EN: wb_irq_i passes through a 2-flop synchronizer before use.
module ksm_vec_fetch #(
    parameter int unsigned TMO   = 64,
    parameter int unsigned TMO_W = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        wb_irq_i,
    input  logic [15:0] wb_dat_i,
    input  logic        wb_ack_i,
    output logic        wb_stb_o,
    output logic        wb_una_o,
    input  logic        vec_req_i,
    input  logic        una_req_i,
    output logic [15:0] dat_o,
    output logic        done_o,
    output logic        tmo_o,
    output logic        kind_o,
    output logic        busy_o
);

    localparam logic [TMO_W-1:0] CNT_MAX  = TMO_W'(TMO);
    localparam logic [TMO_W-1:0] CNT_LAST = TMO_W'(TMO - 1);

    typedef enum logic [1:0] {S_IDLE, S_CYC, S_GAP} state_t;

    state_t           state, state_nx;
    logic             pend_vec, pend_una;
    logic             pend_vec_nx, pend_una_nx;
    logic             clr_vec, clr_una;
    logic [TMO_W-1:0] cnt, cnt_d, cnt_inc;
    logic             cnt_last;
    logic             irq;
    logic             stb_d, una_d, done_d, tmo_d, kind_d, busy_d;
    logic [15:0]      dat_d;

`ifdef KSM_VF_IRQSYNC_EN
    logic [1:0] irq_sync;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) irq_sync <= 2'b00;
        else             irq_sync <= {irq_sync[0], wb_irq_i};
    end

    assign irq = irq_sync[1];
`else
    assign irq = wb_irq_i;
`endif

    assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + TMO_W'(1);
    assign cnt_last = (cnt == CNT_LAST);

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) state <= S_IDLE;
        else             state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (pend_una || (pend_vec && irq)) state_nx = S_CYC;
            S_CYC:   if (wb_ack_i || cnt_last)          state_nx = S_GAP;
            S_GAP:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Next values for all registered outputs, pending-flag clears and the timeout counter
    always_comb begin
        stb_d   = 1'b0;
        una_d   = 1'b0;
        done_d  = 1'b0;
        tmo_d   = 1'b0;
        kind_d  = kind_o;
        dat_d   = dat_o;
        clr_vec = 1'b0;
        clr_una = 1'b0;
        cnt_d   = cnt;
        case (state)
            S_IDLE: begin
                if (pend_una) begin
                    stb_d = 1'b1;
                    una_d = 1'b1;
                    cnt_d = '0;
                end else if (pend_vec && irq) begin
                    stb_d = 1'b1;
                    cnt_d = '0;
                end else if (pend_vec) begin
                    if (cnt_last) begin
                        tmo_d   = 1'b1;
                        kind_d  = 1'b0;
                        clr_vec = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            S_CYC: begin
                if (wb_ack_i) begin
                    done_d  = 1'b1;
                    kind_d  = wb_una_o;
                    dat_d   = wb_dat_i;
                    clr_una = wb_una_o;
                    clr_vec = ~wb_una_o;
                end else if (cnt_last) begin
                    tmo_d   = 1'b1;
                    kind_d  = wb_una_o;
                    clr_una = wb_una_o;
                    clr_vec = ~wb_una_o;
                end else begin
                    stb_d = 1'b1;
                    una_d = wb_una_o;
                    cnt_d = cnt_inc;
                end
            end
            S_GAP:   cnt_d = '0;
            default: cnt_d = '0;
        endcase
    end

    // A new request in the same cycle as its flag's clear keeps the flag set
    assign pend_vec_nx = vec_req_i | (pend_vec & ~clr_vec);
    assign pend_una_nx = una_req_i | (pend_una & ~clr_una);
    assign busy_d      = pend_vec_nx | pend_una_nx | (state_nx != S_IDLE);

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            pend_vec <= 1'b0;
            pend_una <= 1'b0;
            cnt      <= '0;
            wb_stb_o <= 1'b0;
            wb_una_o <= 1'b0;
            dat_o    <= 16'h0000;
            done_o   <= 1'b0;
            tmo_o    <= 1'b0;
            kind_o   <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            pend_vec <= pend_vec_nx;
            pend_una <= pend_una_nx;
            cnt      <= cnt_d;
            wb_stb_o <= stb_d;
            wb_una_o <= una_d;
            dat_o    <= dat_d;
            done_o   <= done_d;
            tmo_o    <= tmo_d;
            kind_o   <= kind_d;
            busy_o   <= busy_d;
        end
    end

endmodule

// File: tb/tb_ksm_vec_fetch.sv
// Bench for ksm_vec_fetch: directed and randomized transactions checked against
// completion times, kinds and data predicted from the cycle-level protocol rules.
module tb_ksm_vec_fetch;

    localparam int unsigned TMO   = 8;
    localparam int unsigned TMO_W = 8;
`ifdef KSM_VF_IRQSYNC_EN
    localparam int IRQ_LAT = 2;
`else
    localparam int IRQ_LAT = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic        irq;
    logic [15:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_stb_o;
    logic        wb_una_o;
    logic        vec_req;
    logic        una_req;
    logic [15:0] dat_o;
    logic        done_o;
    logic        tmo_o;
    logic        kind_o;
    logic        busy_o;

    ksm_vec_fetch #(.TMO(TMO), .TMO_W(TMO_W)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .wb_irq_i   (irq),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i),
        .wb_stb_o   (wb_stb_o),
        .wb_una_o   (wb_una_o),
        .vec_req_i  (vec_req),
        .una_req_i  (una_req),
        .dat_o      (dat_o),
        .done_o     (done_o),
        .tmo_o      (tmo_o),
        .kind_o     (kind_o),
        .busy_o     (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk) cyc = cyc + 1;

    // Responder: acks after the strobe has been high ack_lat cycles
    int          ack_lat;
    bit          force_ack;
    logic [15:0] una_dat, vec_dat;
    int          hi_cnt;
    always @(negedge clk) begin
        if (wb_stb_o) hi_cnt = hi_cnt + 1;
        else          hi_cnt = 0;
        wb_ack_i = force_ack || (wb_stb_o && (hi_cnt == ack_lat));
        if (wb_stb_o) wb_dat_i = wb_una_o ? una_dat : vec_dat;
        else          wb_dat_i = 16'($urandom);
    end

    // Monitor: records completion events and strobe activity
    int          ev_cyc [256];
    bit          ev_tmo [256];
    bit          ev_kind[256];
    logic [15:0] ev_dat [256];
    int          ev_wr, stb_cyc, una_cyc, both_cnt;
    always @(negedge clk) begin
        if ((done_o || tmo_o) && ev_wr < 256) begin
            ev_cyc[ev_wr]  = cyc;
            ev_tmo[ev_wr]  = tmo_o;
            ev_kind[ev_wr] = kind_o;
            ev_dat[ev_wr]  = dat_o;
            ev_wr = ev_wr + 1;
        end
        if (done_o && tmo_o) both_cnt = both_cnt + 1;
        if (wb_stb_o) stb_cyc = stb_cyc + 1;
        if (wb_una_o) una_cyc = una_cyc + 1;
    end

    int          n_checks, n_errors;
    int          ev_rd, s0, u0;
    logic [15:0] last_dat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mark();
        ev_rd = ev_wr;
        s0    = stb_cyc;
        u0    = una_cyc;
    endtask

    task automatic req(input bit v, input bit u, output int e);
        vec_req = v;
        una_req = u;
        tick();
        e       = cyc;
        vec_req = 1'b0;
        una_req = 1'b0;
    endtask

    task automatic wait_quiet(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while ((busy_o || wb_stb_o) && n < 60);
        check({tag, "_idle"}, 32'(busy_o), 32'(0));
        tick();
    endtask

    task automatic expect_ev(input string tag, input int ecyc, input bit etmo,
                             input bit ekind, input logic [15:0] edat);
        int          c = -1;
        logic        t = 1'bx;
        logic        k = 1'bx;
        logic [15:0] d = 16'hxxxx;
        if (ev_rd < ev_wr) begin
            c = ev_cyc[ev_rd];
            t = ev_tmo[ev_rd];
            k = ev_kind[ev_rd];
            d = ev_dat[ev_rd];
            ev_rd++;
        end
        check({tag, "_cyc"},  32'(c), 32'(ecyc));
        check({tag, "_tmo"},  32'(t), 32'(etmo));
        check({tag, "_kind"}, 32'(k), 32'(ekind));
        check({tag, "_dat"},  32'(d), 32'(edat));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_stb"},  32'(wb_stb_o), 32'(0));
        check({tag, "_una"},  32'(wb_una_o), 32'(0));
        check({tag, "_dat"},  32'(dat_o),    32'(0));
        check({tag, "_done"}, 32'(done_o),   32'(0));
        check({tag, "_tmo"},  32'(tmo_o),    32'(0));
        check({tag, "_kind"}, 32'(kind_o),   32'(0));
        check({tag, "_busy"}, 32'(busy_o),   32'(0));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, observed=hang expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e, lat;
        bit u;
        logic [15:0] d;

        rst_n = 1'b0; irq = 1'b0; vec_req = 1'b0; una_req = 1'b0;
        ack_lat = 1; force_ack = 1'b0; una_dat = 16'h0; vec_dat = 16'h0;
        last_dat = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        tick();

        // Unaddressed read of the start-mode register
        mark();
        una_dat = 16'o000340;
        req(1'b0, 1'b1, e);
        wait_quiet("una");
        check("una_nev", 32'(ev_wr - ev_rd), 32'(1));
        expect_ev("una", e + 2, 1'b0, 1'b1, 16'o000340);
        check("una_stb", 32'(stb_cyc - s0), 32'(1));
        check("una_una", 32'(una_cyc - u0), 32'(1));
        last_dat = 16'o000340;

        // Interrupt vector fetch
        irq = 1'b1;
        repeat (4) tick();
        mark();
        vec_dat = 16'o000060;
        req(1'b1, 1'b0, e);
        wait_quiet("vec");
        expect_ev("vec", e + 2, 1'b0, 1'b0, 16'o000060);
        check("vec_una", 32'(una_cyc - u0), 32'(0));
        last_dat = 16'o000060;

        // Both requests together: unaddressed first, gap + idle, then vector
        mark();
        una_dat = 16'($urandom);
        vec_dat = 16'($urandom);
        req(1'b1, 1'b1, e);
        wait_quiet("both");
        check("both_nev", 32'(ev_wr - ev_rd), 32'(2));
        expect_ev("both_u", e + 2, 1'b0, 1'b1, una_dat);
        expect_ev("both_v", e + 5, 1'b0, 1'b0, vec_dat);
        check("both_stb", 32'(stb_cyc - s0), 32'(2));
        last_dat = vec_dat;

        // Vector cycle never acked
        mark();
        ack_lat = 1000;
        req(1'b1, 1'b0, e);
        wait_quiet("tmo");
        expect_ev("tmo", e + 1 + int'(TMO), 1'b1, 1'b0, last_dat);
        check("tmo_stb", 32'(stb_cyc - s0), 32'(TMO));

        // Random transactions around the timeout boundary
        for (int i = 0; i < 16; i++) begin
            mark();
            lat = $urandom_range(1, TMO + 2);
            u   = 1'($urandom_range(0, 1));
            d   = 16'($urandom);
            ack_lat = lat;
            una_dat = d;
            vec_dat = d;
            req(!u, u, e);
            wait_quiet("rnd");
            if (lat <= int'(TMO)) begin
                expect_ev("rnd", e + 1 + lat, 1'b0, u, d);
                check("rnd_stb", 32'(stb_cyc - s0), 32'(lat));
                last_dat = d;
            end else begin
                expect_ev("rnd", e + 1 + int'(TMO), 1'b1, u, last_dat);
                check("rnd_stb", 32'(stb_cyc - s0), 32'(TMO));
            end
        end

        // Vector request with no interrupt: timeout while idle, no strobe
        irq = 1'b0;
        ack_lat = 1;
        repeat (4) tick();
        mark();
        req(1'b1, 1'b0, e);
        wait_quiet("irqwait");
        expect_ev("irqwait", e + int'(TMO), 1'b1, 1'b0, last_dat);
        check("irqwait_stb", 32'(stb_cyc - s0), 32'(0));

        // Interrupt rising three cycles after the request
        mark();
        vec_dat = 16'($urandom);
        req(1'b1, 1'b0, e);
        repeat (3) tick();
        irq = 1'b1;
        wait_quiet("irqlate");
        expect_ev("irqlate", e + 5 + IRQ_LAT, 1'b0, 1'b0, vec_dat);
        last_dat = vec_dat;

        // Stray ack outside a cycle
        mark();
        force_ack = 1'b1;
        repeat (6) tick();
        force_ack = 1'b0;
        repeat (2) tick();
        check("stray_nev", 32'(ev_wr - ev_rd), 32'(0));
        check("stray_stb", 32'(stb_cyc - s0), 32'(0));
        check("stray_dat", 32'(dat_o), 32'(last_dat));

        // Asynchronous reset in the middle of a cycle
        mark();
        ack_lat = 1000;
        req(1'b0, 1'b1, e);
        repeat (3) tick();
        check("rstcyc_stb_pre", 32'(wb_stb_o), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        check_zero("rstcyc");
        #1 rst_n = 1'b1;
        repeat (12) tick();
        check("rstcyc_nev", 32'(ev_wr - ev_rd), 32'(0));
        check("rstcyc_busy", 32'(busy_o), 32'(0));
        check("rstcyc_stb", 32'(wb_stb_o), 32'(0));

        check("done_tmo_excl", 32'(both_cnt), 32'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
